// File: rtl/sigma_timer.sv
// sigma_timer: memory-mapped 32-bit timer/compare peripheral with level compare-match IRQ.
// Optional capture input enabled by defining SIGMA_TIMER_CAPTURE_EN.
module sigma_timer #(
   parameter int          PRESCALE_WIDTH = 16,
   parameter logic [31:0] COMPARE_RST    = 32'hFFFFFFFF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        bus_req,
   input  logic        bus_we,
   input  logic [31:0] bus_addr,
   input  logic [3:0]  bus_be,
   input  logic [31:0] bus_wdata,
   output logic        bus_ack,
   output logic        bus_resp,
   output logic [31:0] bus_rdata,
`ifdef SIGMA_TIMER_CAPTURE_EN
   input  logic        capture_i,
`endif
   output logic        irq_o
);
   logic [2:0]                ctrl;
   logic [PRESCALE_WIDTH-1:0] prescale, pcnt;
   logic [31:0]               count, compare, cap_val, rval, wmask, pre_m;
   logic                      match, wr, rd, tick, hit;
   logic                      w_ctrl, w_pre, w_cnt, w_cmp, w_clr;
   logic [2:0]                sel;
   logic                      unused;
   assign sel     = bus_addr[4:2];
   assign bus_ack = bus_req;
   assign wr      = bus_req & bus_we;
   assign rd      = bus_req & ~bus_we;
   assign wmask   = {{8{bus_be[3]}}, {8{bus_be[2]}}, {8{bus_be[1]}}, {8{bus_be[0]}}};
   assign w_ctrl  = wr && sel == 3'd0 && bus_be[0];
   assign w_pre   = wr && sel == 3'd1 && |bus_be;
   assign w_cnt   = wr && sel == 3'd2 && |bus_be;
   assign w_cmp   = wr && sel == 3'd3;
   assign w_clr   = wr && sel == 3'd4 && bus_be[0] && bus_wdata[0];
   assign pre_m   = (32'(prescale) & ~wmask) | (bus_wdata & wmask);
   assign tick    = ctrl[0] && pcnt == prescale;
   assign hit     = count == compare;
   assign irq_o   = match & ctrl[2];
   assign unused  = ^{bus_addr[31:5], bus_addr[1:0], pre_m[31:PRESCALE_WIDTH]};
   always_comb begin
      rval = sel == 3'd0 ? {29'b0, ctrl} :
             sel == 3'd1 ? 32'(prescale) :
             sel == 3'd2 ? count :
             sel == 3'd3 ? compare :
             sel == 3'd4 ? {31'b0, match} :
             sel == 3'd5 ? cap_val : 32'b0;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bus_resp  <= 1'b0;
         bus_rdata <= '0;
         ctrl      <= '0;
         prescale  <= '0;
         pcnt      <= '0;
         count     <= '0;
         compare   <= COMPARE_RST;
         match     <= 1'b0;
      end else begin
         bus_resp  <= rd;
         bus_rdata <= rd ? rval : '0;
         if (w_ctrl) ctrl <= bus_wdata[2:0];
         if (w_pre) prescale <= pre_m[PRESCALE_WIDTH-1:0];
         pcnt <= (w_pre || !ctrl[0] || tick) ? '0 : pcnt + PRESCALE_WIDTH'(1);
         // a bus write to COUNT takes priority over the tick increment
         count <= w_cnt ? (count & ~wmask) | (bus_wdata & wmask) :
                  tick  ? ((hit && ctrl[1]) ? 32'd0 : count + 32'd1) : count;
         if (w_cmp) compare <= (compare & ~wmask) | (bus_wdata & wmask);
         match <= (tick && hit) ? 1'b1 : w_clr ? 1'b0 : match;
      end
   end
`ifdef SIGMA_TIMER_CAPTURE_EN
   logic [2:0]  sync;
   logic [31:0] capture;
   assign cap_val = capture;
   // sync[1] is the synchronised input, sync[2] its previous value for edge detection
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync    <= '0;
         capture <= '0;
      end else begin
         sync <= {sync[1:0], capture_i};
         if (sync[1] && !sync[2]) capture <= count;
      end
   end
`else
   assign cap_val = 32'b0;
`endif
endmodule

// File: tb/tb_sigma_timer.sv
// tb_sigma_timer: scoreboard bench for sigma_timer; reads push expectations, a monitor pops on bus_resp.
module tb_sigma_timer;
   logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  be = '0;
   logic        ack, resp, irq;
   logic [31:0] rdata;
`ifdef SIGMA_TIMER_CAPTURE_EN
   logic        cap = 1'b0;
`endif
   int total = 0, bad = 0, cyc = 0, resp_cnt = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sigma_timer dut (
      .clk_i(clk), .rst_i(rst), .bus_req(req), .bus_we(we), .bus_addr(addr),
      .bus_be(be), .bus_wdata(wdata), .bus_ack(ack), .bus_resp(resp), .bus_rdata(rdata),
`ifdef SIGMA_TIMER_CAPTURE_EN
      .capture_i(cap),
`endif
      .irq_o(irq)
   );

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (resp) begin
            resp_cnt++;
            if (exp_q.size() == 0) chk("spurious resp", 32'(resp), 32'd0);
            else chk(name_q.pop_front(), rdata, exp_q.pop_front());
         end else chk("rdata idle", rdata, 32'd0);
      end
   end

   // drive one transaction sampled at edge cyc+1; returns at the following negedge
   task automatic op(input bit w, input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
      req = 1'b1; we = w; addr = {27'b0, a, 2'b0}; wdata = d; be = b;
      #1 chk("ack", 32'(ack), 32'd1);
      @(negedge clk);
      req = 1'b0; we = 1'b0; be = '0;
   endtask
   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b = 4'hF);
      op(1'b1, a, d, b);
   endtask
   task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
      exp_q.push_back(e);
      name_q.push_back(n);
      op(1'b0, a, 32'd0, 4'h0);
   endtask
   task automatic wait_edge(input int e);
      while (cyc + 1 < e) @(negedge clk);
   endtask
   task automatic idle(input int k);
      repeat (k) @(negedge clk);
   endtask

   // reference: counting from s enabled at edge t0, prescale p; ticks visible to a read at edge e
   function automatic int n_ticks(input int e, input int t0, input int p);
      return (e - t0 - 1) / (p + 1);
   endfunction
   function automatic logic [31:0] m_count(input logic [31:0] s, input int n);
      return s + 32'(n);
   endfunction
   function automatic logic [31:0] m_match(input logic [31:0] s, input logic [31:0] c, input int n);
      logic [31:0] d;
      d = c - s;
      return {31'b0, d < 32'(n)};
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int t0, p, n0;
      logic [31:0] s, c;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("irq reset", 32'(irq), 32'd0);
      rd(0, 32'd0, "ctrl reset");
      rd(1, 32'd0, "prescale reset");
      rd(2, 32'd0, "count reset");
      rd(3, 32'hFFFFFFFF, "compare reset");
      rd(4, 32'd0, "status reset");
      rd(5, 32'd0, "capture reset");
      rd(6, 32'd0, "addr6");
      rd(7, 32'd0, "addr7");
      wr(0, 32'hFFFFFFFF);
      wr(1, 32'hFFFFFFFF);
      wr(5, 32'h12345678);
      wr(7, 32'h12345678);
      rd(0, 32'd7, "ctrl mask");
      rd(1, 32'h0000FFFF, "prescale width");
      rd(7, 32'd0, "addr7 write ignored");
      wr(0, 32'd0);
      // prescale 3, compare 5, autoreload + irq
      wr(1, 32'd3); wr(3, 32'd5); wr(2, 32'd0); wr(4, 32'd1);
      t0 = cyc + 1;
      wr(0, 32'd7);
      wait_edge(t0 + 24);
      chk("irq before match", 32'(irq), 32'd0);
      rd(2, 32'd5, "count at match tick");
      chk("irq after match", 32'(irq), 32'd1);
      rd(2, 32'd0, "count autoreload");
      rd(4, 32'd1, "status match");
      // wrap at prescale 0, no autoreload
      wr(0, 32'd0); wr(4, 32'd1); wr(1, 32'd0); wr(3, 32'd3); wr(2, 32'hFFFFFFFE);
      t0 = cyc + 1;
      wr(0, 32'd1);
      for (int k = 0; k < 4; k++) rd(2, m_count(32'hFFFFFFFE, n_ticks(cyc + 1, t0, 0)), "wrap count");
      wait_edge(t0 + 6);
      rd(4, m_match(32'hFFFFFFFE, 32'd3, n_ticks(t0 + 6, t0, 0)), "no match before compare");
      rd(4, m_match(32'hFFFFFFFE, 32'd3, n_ticks(t0 + 7, t0, 0)), "match at compare");
      chk("irq disabled", 32'(irq), 32'd0);
      // W1C on the exact match-tick edge
      wr(0, 32'd0); wr(4, 32'd1); wr(3, 32'd10); wr(2, 32'd8);
      t0 = cyc + 1;
      wr(0, 32'd5);
      wait_edge(t0 + 3);
      wr(4, 32'd1);
      rd(4, 32'd1, "match set wins");
      chk("irq set wins", 32'(irq), 32'd1);
      wr(4, 32'd1);
      chk("irq cleared", 32'(irq), 32'd0);
      rd(4, 32'd0, "status cleared");
      // byte enables, frozen count, back-to-back reads
      wr(0, 32'd0); wr(3, 32'hFFFFFFFF);
      wr(3, 32'h0000AB00, 4'b0010);
      wr(2, 32'd42);
      n0 = resp_cnt;
      rd(3, 32'hFFFFABFF, "byte write");
      rd(3, 32'hFFFFABFF, "back-to-back read");
      idle(1);
      chk("b2b resp pulses", 32'(resp_cnt - n0), 32'd2);
      idle(4);
      rd(2, 32'd42, "count frozen");
      // randomized runs against the arithmetic model
      for (int it = 0; it < 20; it++) begin
         p = int'($urandom_range(0, 5));
         s = (it % 3 == 0) ? 32'hFFFFFFF0 + $urandom_range(0, 15) : $urandom;
         c = s + $urandom_range(0, 30);
         wr(0, 32'd0); wr(4, 32'd1); wr(1, 32'(p)); wr(3, c); wr(2, s);
         t0 = cyc + 1;
         wr(0, 32'd1);
         for (int k = 0; k < 4; k++) begin
            idle(int'($urandom_range(0, 12)));
            rd(2, m_count(s, n_ticks(cyc + 1, t0, p)), "rand count");
            rd(4, m_match(s, c, n_ticks(cyc + 1, t0, p)), "rand match");
         end
      end
`ifdef SIGMA_TIMER_CAPTURE_EN
      wr(0, 32'd0); wr(1, 32'd9); wr(2, 32'd100);
      t0 = cyc + 1;
      wr(0, 32'd1);
      cap = 1'b1;
      @(negedge clk);
      cap = 1'b0;
      wait_edge(t0 + 6);
      rd(5, 32'd100, "capture value");
`else
      rd(5, 32'd0, "capture absent");
`endif
      // asynchronous reset mid-count with a read in flight
      wr(0, 32'd0); wr(4, 32'd1); wr(1, 32'd0); wr(3, 32'd2); wr(2, 32'd0); wr(0, 32'd5);
      idle(6);
      chk("irq before reset", 32'(irq), 32'd1);
      req = 1'b1; we = 1'b0; addr = 32'd8;
      @(posedge clk);
      #1 chk("resp in flight", 32'(resp), 32'd1);
      rst = 1'b1; req = 1'b0;
      #1;
      chk("resp dropped", 32'(resp), 32'd0);
      chk("rdata reset", rdata, 32'd0);
      chk("irq reset async", 32'(irq), 32'd0);
      exp_q.delete();
      name_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rd(2, 32'd0, "count after reset");
      rd(3, 32'hFFFFFFFF, "compare after reset");
      rd(0, 32'd0, "ctrl after reset");
      idle(3);
      rd(2, 32'd0, "count idle after reset");
      repeat (3) @(negedge clk);
      chk("queue drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
